// File: rtl/cpu_imem_loader.sv
// cpu_imem_loader: banked instruction memory with a byte-stream image loader.
// The CPU fetches from the active bank while the loader streams a frame into
// another bank. A good frame (matching checksum, legal target) swaps the
// active bank. Failed frames leave the active bank unchanged.
//
// Frame: A5 | bank | len_lo | len_hi | N*(width/8) data bytes (LE) | csum
//   csum = 8-bit sum of bank, length and data bytes.
//
// Ports:
//   clk          system clock
//   reset        async active-low reset
//   iaddr        CPU fetch address
//   idata        fetched word, 1-cycle latency from iaddr
//   ld_valid     loader byte valid
//   ld_data      loader byte
//   ld_ready     loader ready (low only in COMMIT)
//   active_bank  bank currently feeding idata
//   busy         frame in progress
//   load_ok      1-cycle pulse, frame accepted and banks swapped
//   load_err     1-cycle pulse, frame rejected
//
// state  | meaning
// IDLE   | hunting for 0xA5 sync, other bytes dropped
// BANK   | expecting target bank byte
// LEN0   | expecting word count low byte
// LEN1   | expecting word count high byte, legality flag latched here
// DATA   | assembling words and writing the target bank
// CSUM   | expecting checksum byte
// COMMIT | swap active bank, loader stalled for this cycle
module cpu_imem_loader #(
  parameter int width       = 16,
  parameter int iaddr_width = 8,
  parameter int nbanks      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [iaddr_width-1:0]     iaddr,
  output logic [width-1:0]           idata,
  input  logic                       ld_valid,
  input  logic [7:0]                 ld_data,
  output logic                       ld_ready,
  output logic [$clog2(nbanks)-1:0]  active_bank,
  output logic                       busy,
  output logic                       load_ok,
  output logic                       load_err
);

  localparam int DEPTH = 2 ** iaddr_width;
  localparam int WB    = width / 8;
  localparam int BIW   = (WB > 1) ? $clog2(WB) : 1;
  localparam int BW    = $clog2(nbanks);

  typedef enum logic [2:0] {
    S_IDLE, S_BANK, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_COMMIT
  } state_t;

  state_t                  state_q;
  logic [BW-1:0]           active_q;
  logic [7:0]              tgt_q;
  logic [7:0]              len_lo_q;
  logic [15:0]             wcnt_q;
  logic [iaddr_width-1:0]  wa_q;
  logic [BIW-1:0]          bidx_q;
  logic [width-1:0]        word_q;
  logic [7:0]              csum_q;
  logic                    bad_q;
  logic [width-1:0]        idata_q;
  logic                    ld_ready_q;
  logic                    busy_q;
  logic                    load_ok_q;
  logic                    load_err_q;

  logic [width-1:0]        mem [nbanks][DEPTH];

  logic                    fire;
  logic                    last_byte;
  logic [width-1:0]        word_d;
  logic [15:0]             n_d;
  logic                    bad_d;
  logic                    wr_en;

  assign fire = ld_valid && ld_ready_q;

  always_comb begin
    word_d = word_q;
    word_d[int'(bidx_q)*8 +: 8] = ld_data;
    last_byte = (int'(bidx_q) == WB - 1);
    n_d = {ld_data, len_lo_q};
    bad_d = (tgt_q >= 8'(nbanks)) ||
            (tgt_q == {{(8-BW){1'b0}}, active_q}) ||
            ({1'b0, n_d} > 17'(DEPTH));
    // a flagged frame still runs to its end but never touches RAM
    wr_en = fire && (state_q == S_DATA) && last_byte && !bad_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[tgt_q[BW-1:0]][wa_q] <= word_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idata_q <= '0;
    else        idata_q <= mem[active_q][iaddr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      active_q   <= '0;
      tgt_q      <= '0;
      len_lo_q   <= '0;
      wcnt_q     <= '0;
      wa_q       <= '0;
      bidx_q     <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      bad_q      <= 1'b0;
      ld_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      load_ok_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      load_ok_q  <= 1'b0;
      load_err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (fire && ld_data == 8'hA5) begin
          csum_q  <= '0;
          busy_q  <= 1'b1;
          state_q <= S_BANK;
        end
        S_BANK: if (fire) begin
          tgt_q   <= ld_data;
          csum_q  <= csum_q + ld_data;
          state_q <= S_LEN0;
        end
        S_LEN0: if (fire) begin
          len_lo_q <= ld_data;
          csum_q   <= csum_q + ld_data;
          state_q  <= S_LEN1;
        end
        S_LEN1: if (fire) begin
          csum_q  <= csum_q + ld_data;
          bad_q   <= bad_d;
          wcnt_q  <= n_d;
          wa_q    <= '0;
          bidx_q  <= '0;
          state_q <= (n_d == 16'd0) ? S_CSUM : S_DATA;
        end
        S_DATA: if (fire) begin
          csum_q <= csum_q + ld_data;
          word_q <= word_d;
          if (last_byte) begin
            bidx_q <= '0;
            wa_q   <= wa_q + 1'b1;
            wcnt_q <= wcnt_q - 16'd1;
            if (wcnt_q == 16'd1) state_q <= S_CSUM;
          end else begin
            bidx_q <= bidx_q + 1'b1;
          end
        end
        S_CSUM: if (fire) begin
          if (!bad_q && csum_q == ld_data) begin
            ld_ready_q <= 1'b0;
            state_q    <= S_COMMIT;
          end else begin
            load_err_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        S_COMMIT: begin
          active_q   <= tgt_q[BW-1:0];
          load_ok_q  <= 1'b1;
          ld_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          ld_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign idata       = idata_q;
  assign ld_ready    = ld_ready_q;
  assign active_bank = active_q;
  assign busy        = busy_q;
  assign load_ok     = load_ok_q;
  assign load_err    = load_err_q;

endmodule

// File: doc/cpu_imem_loader.md
Name: cpu_imem_loader

Overview:
- Multi-bank instruction memory for the CPU top, with a byte-stream program loader replacing the raw iaddr/idata write port.
- The CPU fetches from the active bank while a new image is streamed into an inactive bank.
- The loader verifies the image with a checksum and swaps the active bank atomically on success.
- Sits between the CPU fetch port and a host byte source (UART or debug bridge).

Parameters:
- width, 16, instruction word width in bits; must be a multiple of 8.
- iaddr_width, 8, instruction address width; depth per bank = 2**iaddr_width.
- nbanks, 2, number of instruction banks; 2..4.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- iaddr  in  iaddr_width  CPU fetch address
- idata  out  width  fetched word, registered
- ld_valid  in  1  loader byte valid
- ld_data  in  8  loader byte
- ld_ready  out  1  loader ready; a byte transfers when ld_valid && ld_ready
- active_bank  out  clog2(nbanks)  bank currently feeding idata
- busy  out  1  frame in progress (state != IDLE)
- load_ok  out  1  one-cycle pulse: frame accepted and banks swapped
- load_err  out  1  one-cycle pulse: frame rejected

Behaviour:
- Reset (async assert, sync release): state=IDLE, active_bank=0, idata=0, load_ok=load_err=0, ld_ready=1. RAM contents are not reset.
- Fetch: idata <= bank[active_bank][iaddr] every clock; 1-cycle latency. A fetch issued in the cycle after the load_ok pulse reads the new bank.
- Frame format, bytes in order:
  - 0xA5 sync
  - bank byte
  - length low byte, then length high byte (word count N, 16 bits)
  - N*(width/8) data bytes, little-endian per word
  - checksum byte = 8-bit sum of the bank, length and data bytes
- FSM:
  - IDLE: discard non-0xA5 bytes; on 0xA5 go to BANK.
  - BANK -> LEN0 -> LEN1.
  - LEN1: if N==0 go to CSUM, else go to DATA.
  - DATA: assemble each word; write it to the target bank at address wa (starting at 0, incrementing per word). After the last byte of word N-1 go to CSUM.
  - CSUM: go to COMMIT if the checksum matches and no bad flag is set; otherwise go to IDLE with a load_err pulse.
  - COMMIT: one cycle; ld_ready=0; active_bank <= target; load_ok pulse; go to IDLE.
- Bad flag, latched at LEN1 when any of these hold:
  - bank byte >= nbanks
  - bank byte == active_bank
  - N > 2**iaddr_width
- With the bad flag set the frame is still consumed to its end, but all RAM writes are suppressed and it finishes with load_err.
- Checksum accumulator is cleared on entry to BANK; wrap-around is modulo 256.
- ld_ready=1 in all states except COMMIT. A byte presented during COMMIT is held by the source and accepted in the next cycle, in IDLE.
- Writes only ever target a bank != active_bank, so there is no read/write collision on the fetch path.
- A failed frame leaves active_bank unchanged. The target bank may hold a partial image; it is never selected.
- 0xA5 inside a frame is ordinary data; resync happens only from IDLE.
- Reset mid-frame: the frame is aborted, active_bank returns to 0, and no load_ok/load_err pulse is emitted.
- load_ok and load_err are mutually exclusive; each is high for exactly one cycle per frame.

Test Plan:
- Good load: after reset, send A5 01 03 00 34 12 EF BE 01 00 F8 -> one load_ok pulse, active_bank=1; iaddr=1 gives idata=0xBEEF one cycle later, iaddr=0 gives 0x1234.
- Bad checksum: the same frame with F7 as last byte -> one load_err pulse, active_bank stays 0, no load_ok.
- Active-bank target: with active_bank=1, send a frame with bank=01 and a valid checksum -> load_err; bank 1 contents unchanged (iaddr=1 still returns 0xBEEF).
- Length overflow: bank=00, N=0x0101 with iaddr_width=8, all N*2 data bytes plus a correct checksum sent -> load_err after the final byte; busy high throughout the frame.
- Reset mid-frame: assert reset after the 5th byte of a good frame -> active_bank=0, busy=0, no pulses; a following good frame to bank 1 gives load_ok.
- Back-to-back: hold ld_valid=1 with byte A5 during COMMIT -> ld_ready=0 for that cycle; the byte is accepted the next cycle and busy rises.
